// File: rtl/mem_encrypt.sv
// rtl/mem_encrypt.sv - RC4 PRGA encryption engine over the shared single-port memory bus
// Reads S, XORs keystream into plaintext and writes ciphertext, one byte per 12-cycle pass.
module mem_encrypt #(
  parameter int MSG_LEN = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_sig,
  input  logic [7:0] q_data,
  output logic       finish,
  output logic       encrypt_mem_handler,
  output logic [7:0] data,
  output logic [7:0] address,
  output logic [1:0] memory_sel,
  output logic       wen
);

  typedef enum logic [3:0] {
    IDLE, RD_SI, W_SI, RD_SJ, W_SJ, WR_SI, WR_SJ,
    RD_F, W_F, RD_P, W_P, WR_C, NEXT, DONE
  } state_t;

  localparam logic [7:0] K_LAST = 8'(MSG_LEN - 1);

  localparam logic [1:0] SEL_S = 2'd0;
  localparam logic [1:0] SEL_P = 2'd1;
  localparam logic [1:0] SEL_C = 2'd2;

  state_t     state_q, state_d;
  logic [7:0] i_q, i_d;
  logic [7:0] j_q, j_d;
  logic [7:0] k_q, k_d;
  logic [7:0] si_q, si_d;
  logic [7:0] sj_q, sj_d;
  logic [7:0] f_q, f_d;

  logic       finish_q, finish_d;
  logic       handler_q, handler_d;
  logic [7:0] data_q, data_d;
  logic [7:0] addr_q, addr_d;
  logic [1:0] sel_q, sel_d;
  logic       wen_q, wen_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      i_q       <= '0;
      j_q       <= '0;
      k_q       <= '0;
      si_q      <= '0;
      sj_q      <= '0;
      f_q       <= '0;
      finish_q  <= 1'b0;
      handler_q <= 1'b0;
      data_q    <= '0;
      addr_q    <= '0;
      sel_q     <= '0;
      wen_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      i_q       <= i_d;
      j_q       <= j_d;
      k_q       <= k_d;
      si_q      <= si_d;
      sj_q      <= sj_d;
      f_q       <= f_d;
      finish_q  <= finish_d;
      handler_q <= handler_d;
      data_q    <= data_d;
      addr_q    <= addr_d;
      sel_q     <= sel_d;
      wen_q     <= wen_d;
    end
  end

  // Outputs are registered, so they are computed from the state being entered.
  // q_data is consumed on the edge leaving each wait state.
  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    j_d     = j_q;
    k_d     = k_q;
    si_d    = si_q;
    sj_d    = sj_q;
    f_d     = f_q;

    case (state_q)
      IDLE, DONE: begin
        if (start_sig) begin
          state_d = RD_SI;
          i_d     = 8'd1;
          j_d     = '0;
          k_d     = '0;
        end
      end
      RD_SI: state_d = W_SI;
      W_SI: begin
        state_d = RD_SJ;
        si_d    = q_data;
        j_d     = j_q + q_data;
      end
      RD_SJ: state_d = W_SJ;
      W_SJ: begin
        state_d = WR_SI;
        sj_d    = q_data;
      end
      WR_SI: state_d = WR_SJ;
      WR_SJ: state_d = RD_F;
      RD_F:  state_d = W_F;
      W_F: begin
        state_d = RD_P;
        f_d     = q_data;
      end
      RD_P: state_d = W_P;
      W_P:  state_d = WR_C;
      WR_C: state_d = NEXT;
      NEXT: begin
        if (k_q == K_LAST) begin
          state_d = DONE;
        end else begin
          state_d = RD_SI;
          k_d     = k_q + 8'd1;
          i_d     = i_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    finish_d  = 1'b0;
    handler_d = 1'b1;
    data_d    = '0;
    addr_d    = '0;
    sel_d     = SEL_S;
    wen_d     = 1'b0;

    case (state_d)
      IDLE: handler_d = 1'b0;
      DONE: begin
        handler_d = 1'b0;
        finish_d  = 1'b1;
      end
      RD_SI, W_SI: addr_d = i_d;
      RD_SJ, W_SJ: addr_d = j_d;
      WR_SI: begin
        addr_d = i_q;
        data_d = sj_d;
        wen_d  = 1'b1;
      end
      WR_SJ: begin
        addr_d = j_q;
        data_d = si_q;
        wen_d  = 1'b1;
      end
      RD_F, W_F: addr_d = si_q + sj_q;
      RD_P, W_P: begin
        addr_d = k_q;
        sel_d  = SEL_P;
      end
      WR_C: begin
        addr_d = k_q;
        data_d = f_q ^ q_data;
        sel_d  = SEL_C;
        wen_d  = 1'b1;
      end
      default: ;
    endcase
  end

  assign finish              = finish_q;
  assign encrypt_mem_handler = handler_q;
  assign data                = data_q;
  assign address             = addr_q;
  assign memory_sel          = sel_q;
  assign wen                 = wen_q;

endmodule

// File: tb/tb_mem_encrypt.sv
// tb/tb_mem_encrypt.sv - self-checking bench for mem_encrypt
// Instance 0 runs MSG_LEN = 3, instance 1 runs MSG_LEN = 32; each has its own S/P/C RAMs.
module tb_mem_encrypt;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       start   [2];
  logic [7:0] q_data  [2];
  logic       finish  [2];
  logic       hnd     [2];
  logic [7:0] data    [2];
  logic [7:0] address [2];
  logic [1:0] sel     [2];
  logic       wen     [2];

  logic [7:0] s_ram [2][256];
  logic [7:0] p_ram [2][256];
  logic [7:0] c_ram [2][256];
  logic [7:0] s_q [2];
  logic [7:0] p_q [2];
  logic [7:0] c_q [2];

  int m_s [2][256];
  int m_p [2][256];
  int m_c [2][256];
  int s0  [256];

  int tests = 0;
  int fails = 0;
  int bus_err [2];
  int wr_cnt  [2][4];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    mem_encrypt #(.MSG_LEN((g == 0) ? 3 : 32)) u_dut (
      .clk                 (clk),
      .reset               (reset),
      .start_sig           (start[g]),
      .q_data              (q_data[g]),
      .finish              (finish[g]),
      .encrypt_mem_handler (hnd[g]),
      .data                (data[g]),
      .address             (address[g]),
      .memory_sel          (sel[g]),
      .wen                 (wen[g])
    );
  end

  always @(posedge clk) begin
    for (int g = 0; g < 2; g++) begin
      s_q[g] <= s_ram[g][address[g]];
      p_q[g] <= p_ram[g][address[g]];
      c_q[g] <= c_ram[g][address[g]];
      if (wen[g]) begin
        case (sel[g])
          2'd0: s_ram[g][address[g]] = data[g];
          2'd1: p_ram[g][address[g]] = data[g];
          2'd2: c_ram[g][address[g]] = data[g];
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    for (int g = 0; g < 2; g++) begin
      q_data[g] = (sel[g] == 2'd0) ? s_q[g] : (sel[g] == 2'd1) ? p_q[g] : c_q[g];
    end
  end

  always @(negedge clk) begin
    for (int g = 0; g < 2; g++) begin
      if (sel[g] == 2'd3) bus_err[g]++;
      if (wen[g] === 1'b1) begin
        if (!((sel[g] == 2'd0) || (sel[g] == 2'd2)) || hnd[g] !== 1'b1) bus_err[g]++;
        wr_cnt[g][sel[g]]++;
      end
    end
  end

  task automatic s_identity(input int g);
    for (int x = 0; x < 256; x++) begin
      m_s[g][x]   = x;
      s_ram[g][x] = 8'(x);
      c_ram[g][x] = 8'h00;
    end
  endtask

  task automatic set_pt(input int g, input int k, input int v);
    p_ram[g][k] = 8'(v);
    m_p[g][k]   = v;
  endtask

  task automatic model_run(input int g, input int len);
    int i = 0;
    int j = 0;
    int t;
    for (int k = 0; k < len; k++) begin
      i = (i + 1) % 256;
      j = (j + m_s[g][i]) % 256;
      t = m_s[g][i];
      m_s[g][i] = m_s[g][j];
      m_s[g][j] = t;
      m_c[g][k] = m_p[g][k] ^ m_s[g][(m_s[g][i] + m_s[g][j]) % 256];
    end
  endtask

  task automatic check_zero_outputs(input int g, input string name);
    tests++;
    if ({finish[g], hnd[g], data[g], address[g], sel[g], wen[g]} !== 20'h0) begin
      fails++;
      $display("FAIL %s: outputs got %0h expected 0", name,
               {finish[g], hnd[g], data[g], address[g], sel[g], wen[g]});
    end
  endtask

  task automatic run(input int g, input int len, input bit mid_pulse);
    int cyc = 0;
    bus_err[g] = 0;
    for (int s = 0; s < 4; s++) wr_cnt[g][s] = 0;
    @(negedge clk);
    start[g] = 1'b1;
    while (1) begin
      @(negedge clk);
      cyc++;
      start[g] = (mid_pulse && (cyc == 10 || cyc == 11)) ? 1'b1 : 1'b0;
      if (cyc == 1) begin
        tests++;
        if (finish[g] !== 1'b0 || hnd[g] !== 1'b1) begin
          fails++;
          $display("FAIL first_busy_cycle: finish=%0b handler=%0b expected 0/1", finish[g], hnd[g]);
        end
      end
      if (finish[g] === 1'b1) break;
      if (cyc > 12 * len + 20) begin
        fails++;
        $display("FAIL timeout: finish not seen after %0d cycles", cyc);
        break;
      end
    end
    start[g] = 1'b0;
    tests++;
    if (cyc != 12 * len + 1) begin
      fails++;
      $display("FAIL latency: got %0d cycles expected %0d", cyc, 12 * len + 1);
    end
    tests++;
    if (wr_cnt[g][0] != 2 * len || wr_cnt[g][1] != 0 || wr_cnt[g][2] != len || wr_cnt[g][3] != 0) begin
      fails++;
      $display("FAIL write_counts: got s=%0d p=%0d c=%0d x=%0d expected s=%0d c=%0d",
               wr_cnt[g][0], wr_cnt[g][1], wr_cnt[g][2], wr_cnt[g][3], 2 * len, len);
    end
    tests++;
    if (bus_err[g] != 0) begin
      fails++;
      $display("FAIL bus_protocol: got %0d violations expected 0", bus_err[g]);
    end
    tests++;
    if (hnd[g] !== 1'b0 || wen[g] !== 1'b0) begin
      fails++;
      $display("FAIL done_outputs: handler=%0b wen=%0b expected 0/0", hnd[g], wen[g]);
    end
  endtask

  task automatic check_ct(input int g, input int len, input string name);
    for (int k = 0; k < len; k++) begin
      tests++;
      if (c_ram[g][k] !== 8'(m_c[g][k])) begin
        fails++;
        $display("FAIL %s[%0d]: got %02h expected %02h", name, k, c_ram[g][k], 8'(m_c[g][k]));
      end
    end
  endtask

  task automatic check_kat(input string name, input logic [23:0] expv);
    logic [23:0] e;
    e = expv;
    for (int k = 0; k < 3; k++) begin
      tests++;
      if (c_ram[0][k] !== e[23-8*k -: 8]) begin
        fails++;
        $display("FAIL %s[%0d]: got %02h expected %02h", name, k, c_ram[0][k], e[23-8*k -: 8]);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check_zero_outputs(0, "reset_state0");
    check_zero_outputs(1, "reset_state1");
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_zero_plaintext();
    s_identity(0);
    for (int k = 0; k < 3; k++) set_pt(0, k, 0);
    model_run(0, 3);
    run(0, 3, 1'b0);
    check_kat("zero_pt", 24'h020507);
    check_ct(0, 3, "zero_pt_model");
  endtask

  task automatic test_abc_mid_start();
    s_identity(0);
    for (int k = 0; k < 3; k++) set_pt(0, k, 8'h41 + k);
    model_run(0, 3);
    run(0, 3, 1'b1);
    check_kat("abc", 24'h434744);
  endtask

  task automatic test_reset_mid_run();
    int n = 0;
    s_identity(0);
    for (int k = 0; k < 3; k++) set_pt(0, k, 0);
    @(negedge clk);
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    while (wen[0] !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (n >= 20 || sel[0] !== 2'd0) begin
      fails++;
      $display("FAIL reach_wr_si: waited %0d cycles sel=%0d expected write to S", n, sel[0]);
    end
    #1 reset = 1'b1;
    #1 check_zero_outputs(0, "async_reset");
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check_zero_outputs(0, "idle_after_reset");
    s_identity(0);
    model_run(0, 3);
    run(0, 3, 1'b0);
    check_kat("after_reset", 24'h020507);
  endtask

  task automatic test_random_ksa();
    logic [7:0] key [3];
    int j = 0;
    int t;
    int bad = 0;
    int i2 = 0;
    int j2 = 0;
    key[0] = 8'h00;
    key[1] = 8'h01;
    key[2] = 8'h23;
    s_identity(1);
    for (int i = 0; i < 256; i++) begin
      j = (j + m_s[1][i] + key[i % 3]) % 256;
      t = m_s[1][i];
      m_s[1][i] = m_s[1][j];
      m_s[1][j] = t;
    end
    for (int x = 0; x < 256; x++) begin
      s_ram[1][x] = 8'(m_s[1][x]);
      s0[x]       = m_s[1][x];
    end
    for (int k = 0; k < 32; k++) set_pt(1, k, int'($urandom_range(0, 255)));
    model_run(1, 32);
    run(1, 32, 1'b0);
    check_ct(1, 32, "ksa_ct");
    for (int k = 0; k < 32; k++) begin
      i2 = (i2 + 1) % 256;
      j2 = (j2 + s0[i2]) % 256;
      t = s0[i2];
      s0[i2] = s0[j2];
      s0[j2] = t;
      if ((c_ram[1][k] ^ 8'(s0[(s0[i2] + s0[j2]) % 256])) !== 8'(m_p[1][k])) bad++;
    end
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL round_trip: got %0d wrong bytes expected 0", bad);
    end
    bad = 0;
    for (int x = 0; x < 256; x++) if (s_ram[1][x] !== 8'(m_s[1][x])) bad++;
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL final_s: got %0d wrong entries expected 0", bad);
    end
  endtask

  task automatic test_done_restart();
    int bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (finish[1] !== 1'b1 || hnd[1] !== 1'b0) bad++;
    end
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL done_hold: got %0d bad cycles expected 0", bad);
    end
    for (int k = 0; k < 32; k++) c_ram[1][k] = 8'h00;
    model_run(1, 32);
    run(1, 32, 1'b0);
    check_ct(1, 32, "restart_ct");
  endtask

  initial begin
    reset    = 1'b1;
    start[0] = 1'b0;
    start[1] = 1'b0;
    bus_err[0] = 0;
    bus_err[1] = 0;
    test_reset();
    test_zero_plaintext();
    test_abc_mid_start();
    test_reset_mid_run();
    test_random_ksa();
    test_done_restart();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_encrypt.md
Name: mem_encrypt

Overview:
- RC4 PRGA encryption engine; the transmit-side counterpart of mem_decrypt.
- Runs after the KSA stage has permuted S RAM.
- Generates keystream from S RAM, XORs it with plaintext RAM and writes ciphertext RAM, MSG_LEN bytes.
- Owns the shared single-port memory bus (address/data/wen/memory_sel) while encrypt_mem_handler is high; an external mux returns the bus to other stages otherwise.

Parameters:
- MSG_LEN, 32: number of message bytes processed; legal range 1..256.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- start_sig  in  1  start request; sampled only in IDLE and DONE.
- q_data  in  8  read data from the memory selected by memory_sel.
- finish  out  1  level high in DONE.
- encrypt_mem_handler  out  1  high while the block owns the memory bus.
- data  out  8  write data.
- address  out  8  memory address.
- memory_sel  out  2  memory select: 0 = S RAM, 1 = plaintext RAM, 2 = ciphertext RAM; 3 is never driven.
- wen  out  1  write enable for the selected memory.

Behaviour:
- Outputs and timing:
  - All outputs are registered Moore outputs. The values listed for a state appear on the ports during the cycle the FSM is in that state.
  - Reset value of every output is 0; state = IDLE; internal i, j, k, si, sj, f are all 0.
  - Memory is synchronous. q_data for an address driven in state X is sampled in the state two cycles later, so each read is followed by one wait state.
- Arithmetic: i, j and every S index are 8-bit and wrap mod 256. k counts 0..MSG_LEN-1.
- IDLE: all outputs 0. If start_sig = 1, go to RD_SI and clear i, j, k.
- Per-byte sequence, 12 cycles; wen = 0 unless stated:
  1. RD_SI: i <= i+1; address = i+1; memory_sel = 0.
  2. W_SI: hold address.
  3. RD_SJ: si <= q_data; j <= j+q_data; address = j+q_data; memory_sel = 0.
  4. W_SJ: hold address.
  5. WR_SI: sj <= q_data; address = i; data = sj; wen = 1; memory_sel = 0.
  6. WR_SJ: address = j; data = si; wen = 1; memory_sel = 0.
  7. RD_F: address = si+sj (mod 256); memory_sel = 0.
  8. W_F: hold address.
  9. RD_P: f <= q_data; address = k; memory_sel = 1.
  10. W_P: hold address.
  11. WR_C: address = k; data = f ^ q_data; wen = 1; memory_sel = 2.
  12. NEXT: if k == MSG_LEN-1 go to DONE, else k <= k+1 and go to RD_SI.
- i == j: both swap writes target the same word with the same value. Legal; S is unchanged.
- encrypt_mem_handler = 1 in every state from RD_SI through NEXT; 0 in IDLE and DONE.
- DONE:
  - finish = 1; encrypt_mem_handler = 0; wen = 0.
  - finish stays high until reset.
  - start_sig = 1 in DONE clears finish and restarts at RD_SI with i, j, k = 0. S is not restored; the caller re-runs KSA first.
- start_sig while busy (RD_SI..NEXT) is ignored.
- Latency: DONE is entered 12*MSG_LEN + 1 cycles after the cycle in which start_sig is sampled in IDLE.
- Reset mid-operation:
  - Asynchronously forces IDLE and all outputs 0 within the same cycle; wen drops immediately.
  - A partially written ciphertext byte and the partially permuted S are left as-is.
- Round-trip property: ciphertext produced here, decrypted by mem_decrypt from the same post-KSA S, reproduces the plaintext exactly.

Test Plan:
- Reset, then start: S RAM preloaded identity (S[x] = x), plaintext all 0x00, MSG_LEN = 3 -> ciphertext 0x02, 0x05, 0x07.
- Same S, plaintext "ABC" (0x41, 0x42, 0x43) -> ciphertext 0x43, 0x47, 0x44; finish rises exactly 37 cycles after start is sampled; encrypt_mem_handler low in IDLE and DONE.
- Bus protocol checks:
  - wen = 1 only in WR_SI, WR_SJ and WR_C, with memory_sel 0, 0, 2 respectively.
  - memory_sel never equals 3.
  - start pulsed mid-run has no effect on the output bytes.
- Assert reset during byte 1, state WR_SI -> all outputs 0 in the same cycle, FSM in IDLE; a new start after S and plaintext are reloaded reproduces 0x02, 0x05, 0x07.
- Random 32-byte plaintext with a KSA-generated S (key 0x000123) -> ciphertext matches the reference-model RC4; feeding it through mem_decrypt returns the plaintext.
- In DONE, hold finish for 20 cycles, then pulse start -> finish drops the next cycle; the run restarts with i = j = 0 and completes again.
